// File: rtl/branch_seq_pkg.sv
// Shared CPU definitions for the branch sequencer: widths, flag positions,
// condition-code constants, FSM encoding and the captured-request payload.
package branch_seq_pkg;

  localparam int unsigned IP_W   = 16;
  localparam int unsigned CX_W   = 16;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned COND_W = 4;

  // Bit positions inside logic_flags = {OF,SF,ZF,PF,CF}
  localparam int unsigned FLAG_OF = 4;
  localparam int unsigned FLAG_SF = 3;
  localparam int unsigned FLAG_ZF = 2;
  localparam int unsigned FLAG_PF = 1;
  localparam int unsigned FLAG_CF = 0;

  localparam logic [COND_W-1:0] JCC_O   = 4'h0;
  localparam logic [COND_W-1:0] JCC_NO  = 4'h1;
  localparam logic [COND_W-1:0] JCC_C   = 4'h2;
  localparam logic [COND_W-1:0] JCC_NC  = 4'h3;
  localparam logic [COND_W-1:0] JCC_Z   = 4'h4;
  localparam logic [COND_W-1:0] JCC_NZ  = 4'h5;
  localparam logic [COND_W-1:0] JCC_BE  = 4'h6;
  localparam logic [COND_W-1:0] JCC_A   = 4'h7;
  localparam logic [COND_W-1:0] JCC_S   = 4'h8;
  localparam logic [COND_W-1:0] JCC_NS  = 4'h9;
  localparam logic [COND_W-1:0] JCC_P   = 4'hA;
  localparam logic [COND_W-1:0] JCC_NP  = 4'hB;
  localparam logic [COND_W-1:0] JCC_L   = 4'hC;
  localparam logic [COND_W-1:0] JCC_GE  = 4'hD;
  localparam logic [COND_W-1:0] JCC_LE  = 4'hE;
  localparam logic [COND_W-1:0] JCC_G   = 4'hF;

  localparam logic [COND_W-1:0] CX_JCXZ   = 4'h0;
  localparam logic [COND_W-1:0] CX_LOOP   = 4'h1;
  localparam logic [COND_W-1:0] CX_LOOPZ  = 4'h2;
  localparam logic [COND_W-1:0] CX_LOOPNZ = 4'h3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_EVAL = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic              is_cx;
    logic [COND_W-1:0] cond;
    logic [IP_W-1:0]   disp;
    logic [IP_W-1:0]   ip_next;
    logic [FLAG_W-1:0] flags;
  } br_req_t;

endpackage

// File: rtl/jmp_cond.sv
// Combinational branch-condition evaluator for Jcc and the CX-class ops
// (jcxz/loop/loopz/loopnz); cond values 3..15 in CX mode all mean loopnz.
module jmp_cond
  import branch_seq_pkg::*;
(
  input  logic              is_cx,
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  input  logic              cx_zero,
  output logic              taken_c
);

  logic of_f, sf_f, zf_f, pf_f, cf_f, lt_f, loopnz_c;

  assign of_f     = flags[FLAG_OF];
  assign sf_f     = flags[FLAG_SF];
  assign zf_f     = flags[FLAG_ZF];
  assign pf_f     = flags[FLAG_PF];
  assign cf_f     = flags[FLAG_CF];
  assign lt_f     = sf_f ^ of_f;
  assign loopnz_c = ~zf_f & ~cx_zero;

  always_comb begin
    taken_c = 1'b0;
    if (is_cx) begin
      case (cond)
        CX_JCXZ:   taken_c = cx_zero;
        CX_LOOP:   taken_c = ~cx_zero;
        CX_LOOPZ:  taken_c = zf_f & ~cx_zero;
        CX_LOOPNZ: taken_c = loopnz_c;
        default:   taken_c = loopnz_c;
      endcase
    end else begin
      case (cond)
        JCC_O:   taken_c = of_f;
        JCC_NO:  taken_c = ~of_f;
        JCC_C:   taken_c = cf_f;
        JCC_NC:  taken_c = ~cf_f;
        JCC_Z:   taken_c = zf_f;
        JCC_NZ:  taken_c = ~zf_f;
        JCC_BE:  taken_c = cf_f | zf_f;
        JCC_A:   taken_c = ~cf_f & ~zf_f;
        JCC_S:   taken_c = sf_f;
        JCC_NS:  taken_c = ~sf_f;
        JCC_P:   taken_c = pf_f;
        JCC_NP:  taken_c = ~pf_f;
        JCC_L:   taken_c = lt_f;
        JCC_GE:  taken_c = ~lt_f;
        JCC_LE:  taken_c = zf_f | lt_f;
        JCC_G:   taken_c = ~zf_f & ~lt_f;
        default: taken_c = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_seq.sv
// Conditional-branch / loop sequencer: captures a decoded request, optionally
// decrements CX, evaluates the condition and holds the outcome until fetch takes it.
module branch_seq
  import branch_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_cx,
  input  logic [COND_W-1:0] cond,
  input  logic [IP_W-1:0]   disp,
  input  logic [IP_W-1:0]   ip_next,
  input  logic [CX_W-1:0]   cx_in,
  input  logic [FLAG_W-1:0] logic_flags,
  output logic              cx_we,
  output logic [CX_W-1:0]   cx_out,
  output logic              br_valid,
  input  logic              br_ready,
  output logic              br_taken,
  output logic [IP_W-1:0]   br_target
);

  state_t          state_q, state_d;
  br_req_t         req_q, req_d;
  logic [CX_W-1:0] cx_q, cx_d;
  logic [CX_W-1:0] cx_dec_q, cx_dec_d;
  logic            taken_q, taken_d;
  logic [IP_W-1:0] target_q, target_d;
  logic            taken_c;

  jmp_cond u_jmp_cond (
    .is_cx   (req_q.is_cx),
    .cond    (req_q.cond),
    .flags   (req_q.flags),
    .cx_zero (cx_q == '0),
    .taken_c (taken_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      cx_q     <= '0;
      cx_dec_q <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cx_q     <= cx_d;
      cx_dec_q <= cx_dec_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  // Flush overrides everything and drops the captured request.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cx_d     = cx_q;
    cx_dec_d = cx_dec_q;
    taken_d  = taken_q;
    target_d = target_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_d.is_cx   = is_cx;
            req_d.cond    = cond;
            req_d.disp    = disp;
            req_d.ip_next = ip_next;
            req_d.flags   = logic_flags;
            cx_d          = cx_in;
            // Decrement precomputed at capture so cx_out is a plain flop in DEC.
            cx_dec_d      = cx_in - CX_W'(1);
            state_d       = (is_cx && cond != '0) ? S_DEC : S_EVAL;
          end
        end
        S_DEC: begin
          cx_d    = cx_dec_q;
          state_d = S_EVAL;
        end
        S_EVAL: begin
          taken_d  = taken_c;
          target_d = taken_c ? IP_W'(req_q.ip_next + req_q.disp) : req_q.ip_next;
          state_d  = S_RESP;
        end
        S_RESP: begin
          if (br_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are masked by flush/rst in the same cycle so an abort never leaks a pulse.
  assign req_ready = (state_q == S_IDLE) && !flush && !rst;
  assign cx_we     = (state_q == S_DEC)  && !flush && !rst;
  assign br_valid  = (state_q == S_RESP) && !flush && !rst;
  assign cx_out    = cx_dec_q;
  assign br_taken  = taken_q;
  assign br_target = target_q;

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq: latency, condition decode, CX decrement/wrap,
// backpressure, flush and reset aborts, with hand-computed expectations.
module tb_branch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        is_cx = 1'b0;
  logic        br_ready = 1'b0;
  logic [3:0]  cond = '0;
  logic [15:0] disp = '0;
  logic [15:0] ip_next = '0;
  logic [15:0] cx_in = '0;
  logic [4:0]  logic_flags = '0;
  logic        req_ready, cx_we, br_valid, br_taken;
  logic [15:0] cx_out, br_target;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_seq dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .is_cx       (is_cx),
    .cond        (cond),
    .disp        (disp),
    .ip_next     (ip_next),
    .cx_in       (cx_in),
    .logic_flags (logic_flags),
    .cx_we       (cx_we),
    .cx_out      (cx_out),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_taken    (br_taken),
    .br_target   (br_target)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input logic x, input logic [3:0] c, input logic [15:0] d,
                         input logic [15:0] ip, input logic [15:0] cx, input logic [4:0] f);
    is_cx = x; cond = c; disp = d; ip_next = ip; cx_in = cx; logic_flags = f;
  endtask

  // Presents a request in IDLE, confirms acceptance, and returns in cycle 1.
  task automatic send(input logic x, input logic [3:0] c, input logic [15:0] d,
                      input logic [15:0] ip, input logic [15:0] cx, input logic [4:0] f);
    set_req(x, c, d, ip, cx, f);
    req_valid = 1'b1;
    #1;
    chk("accept_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    br_ready = 1'b1;
    step();
    br_ready = 1'b0;
    #1;
    chk({tag, "_idle_ready"}, req_ready, 1'b1);
    chk({tag, "_idle_valid"}, br_valid, 1'b0);
  endtask

  task automatic run_jcc(input string tag, input logic [3:0] c, input logic [4:0] f,
                         input logic [15:0] ip, input logic [15:0] d,
                         input logic exp_taken, input logic [15:0] exp_tgt);
    send(1'b0, c, d, ip, 16'h1234, f);
    chk({tag, "_c1_valid"}, br_valid, 1'b0);
    chk({tag, "_c1_cxwe"}, cx_we, 1'b0);
    step();
    chk({tag, "_c2_valid"}, br_valid, 1'b1);
    chk({tag, "_taken"}, br_taken, exp_taken);
    chk({tag, "_target"}, br_target, exp_tgt);
    chk({tag, "_c2_cxwe"}, cx_we, 1'b0);
    handshake(tag);
  endtask

  task automatic run_loop(input string tag, input logic [3:0] c, input logic [15:0] cx,
                          input logic [4:0] f, input logic [15:0] ip, input logic [15:0] d,
                          input logic [15:0] exp_cx, input logic exp_taken,
                          input logic [15:0] exp_tgt);
    send(1'b1, c, d, ip, cx, f);
    chk({tag, "_dec_cxwe"}, cx_we, 1'b1);
    chk({tag, "_dec_cxout"}, cx_out, exp_cx);
    chk({tag, "_dec_valid"}, br_valid, 1'b0);
    step();
    chk({tag, "_c2_cxwe"}, cx_we, 1'b0);
    chk({tag, "_c2_valid"}, br_valid, 1'b0);
    step();
    chk({tag, "_c3_valid"}, br_valid, 1'b1);
    chk({tag, "_taken"}, br_taken, exp_taken);
    chk({tag, "_target"}, br_target, exp_tgt);
    handshake(tag);
  endtask

  task automatic run_jcxz(input string tag, input logic [15:0] cx, input logic [15:0] ip,
                          input logic [15:0] d, input logic exp_taken,
                          input logic [15:0] exp_tgt);
    send(1'b1, 4'h0, d, ip, cx, 5'b00000);
    chk({tag, "_c1_cxwe"}, cx_we, 1'b0);
    chk({tag, "_c1_valid"}, br_valid, 1'b0);
    step();
    chk({tag, "_c2_valid"}, br_valid, 1'b1);
    chk({tag, "_c2_cxwe"}, cx_we, 1'b0);
    chk({tag, "_taken"}, br_taken, exp_taken);
    chk({tag, "_target"}, br_target, exp_tgt);
    handshake(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    step();
    step();
    chk("rst_cxwe", cx_we, 1'b0);
    chk("rst_valid", br_valid, 1'b0);
    chk("rst_taken", br_taken, 1'b0);
    chk("rst_cxout", cx_out, 16'h0000);
    chk("rst_target", br_target, 16'h0000);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", req_ready, 1'b1);

    // Jcc decode and target arithmetic
    run_jcc("jz",     4'h4, 5'b00100, 16'h0100, 16'hFFF0, 1'b1, 16'h00F0);
    run_jcc("jz_nt",  4'h4, 5'b00000, 16'h0100, 16'hFFF0, 1'b0, 16'h0100);
    run_jcc("jl",     4'hC, 5'b10000, 16'h2000, 16'h0010, 1'b1, 16'h2010);
    run_jcc("jg",     4'hF, 5'b11000, 16'h2000, 16'h0010, 1'b1, 16'h2010);
    run_jcc("jle_nt", 4'hE, 5'b11000, 16'h2000, 16'h0010, 1'b0, 16'h2000);
    run_jcc("jnp_nt", 4'hB, 5'b00010, 16'h2000, 16'h0010, 1'b0, 16'h2000);
    run_jcc("ja_nt",  4'h7, 5'b00001, 16'h2000, 16'h0010, 1'b0, 16'h2000);
    run_jcc("jo",     4'h0, 5'b10000, 16'hFFFE, 16'h0004, 1'b1, 16'h0002);

    // Loop family: decrement, wrap, ZF qualification
    run_loop("loop_wrap",  4'h1, 16'h0000, 5'b00000, 16'h1000, 16'h0004, 16'hFFFF, 1'b1, 16'h1004);
    run_loop("loopz",      4'h2, 16'h0005, 5'b00100, 16'h1000, 16'h0004, 16'h0004, 1'b1, 16'h1004);
    run_loop("loopz_nt",   4'h2, 16'h0005, 5'b00000, 16'h1000, 16'h0004, 16'h0004, 1'b0, 16'h1000);
    run_loop("loopnz9",    4'h9, 16'h0005, 5'b00000, 16'h1000, 16'h0004, 16'h0004, 1'b1, 16'h1004);
    run_loop("loopnz_cx0", 4'h3, 16'h0001, 5'b00000, 16'h1000, 16'h0004, 16'h0000, 1'b0, 16'h1000);

    // jcxz: no decrement, two-cycle latency, wrapping target
    run_jcxz("jcxz",    16'h0000, 16'hFFF0, 16'h0020, 1'b1, 16'h0010);
    run_jcxz("jcxz_nt", 16'h0001, 16'hFFF0, 16'h0020, 1'b0, 16'hFFF0);

    // loop with CX=1 falls through; outcome held under 5 cycles of backpressure
    send(1'b1, 4'h1, 16'h0010, 16'h0200, 16'h0001, 5'b00000);
    chk("hold_dec_cxwe", cx_we, 1'b1);
    chk("hold_dec_cxout", cx_out, 16'h0000);
    step();
    chk("hold_c2_cxwe", cx_we, 1'b0);
    chk("hold_c2_valid", br_valid, 1'b0);
    step();
    set_req(1'b0, 4'h4, 16'h0005, 16'h0300, 16'h0000, 5'b00000);
    req_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", br_valid, 1'b1);
      chk("hold_taken", br_taken, 1'b0);
      chk("hold_target", br_target, 16'h0200);
      chk("hold_ready", req_ready, 1'b0);
      chk("hold_cxwe", cx_we, 1'b0);
      if (i < 4) step();
    end
    br_ready = 1'b1;
    #1;
    chk("resp_done_no_accept", req_ready, 1'b0);
    step();
    br_ready = 1'b0;
    #1;
    chk("after_resp_ready", req_ready, 1'b1);
    chk("after_resp_valid", br_valid, 1'b0);
    step();
    req_valid = 1'b0;
    chk("next_eval_valid", br_valid, 1'b0);
    step();
    chk("next_valid", br_valid, 1'b1);
    chk("next_taken", br_taken, 1'b0);
    chk("next_target", br_target, 16'h0300);
    handshake("next");

    // Flush in IDLE blocks acceptance
    set_req(1'b1, 4'h1, 16'h0010, 16'h0400, 16'h0003, 5'b00000);
    req_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_idle_ready", req_ready, 1'b0);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("flush_idle_cxwe", cx_we, 1'b0);
    chk("flush_idle_ready2", req_ready, 1'b1);
    step();
    chk("flush_idle_v1", br_valid, 1'b0);
    step();
    chk("flush_idle_v2", br_valid, 1'b0);

    // Flush during DEC
    send(1'b1, 4'h1, 16'h0010, 16'h0400, 16'h0003, 5'b00000);
    flush = 1'b1;
    #1;
    chk("flush_dec_cxwe", cx_we, 1'b0);
    chk("flush_dec_valid", br_valid, 1'b0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_dec_ready", req_ready, 1'b1);
    chk("flush_dec_cxwe2", cx_we, 1'b0);
    chk("flush_dec_valid2", br_valid, 1'b0);
    step();
    chk("flush_dec_valid3", br_valid, 1'b0);
    step();
    chk("flush_dec_valid4", br_valid, 1'b0);

    // Reset during DEC
    send(1'b1, 4'h1, 16'h0010, 16'h0400, 16'h0003, 5'b00000);
    rst = 1'b1;
    #1;
    chk("rst_dec_cxwe", cx_we, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_dec_ready", req_ready, 1'b1);
    chk("rst_dec_cxout", cx_out, 16'h0000);
    step();
    chk("rst_dec_cxwe2", cx_we, 1'b0);
    chk("rst_dec_valid", br_valid, 1'b0);

    // Reset during EVAL, right after a taken branch left br_taken=1
    run_jcc("pre_rst", 4'h4, 5'b00100, 16'h0100, 16'h0010, 1'b1, 16'h0110);
    send(1'b0, 4'h4, 16'h0010, 16'h0500, 16'h0000, 5'b00100);
    rst = 1'b1;
    #1;
    chk("rst_eval_valid", br_valid, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_eval_ready", req_ready, 1'b1);
    chk("rst_eval_valid2", br_valid, 1'b0);
    chk("rst_eval_taken", br_taken, 1'b0);
    chk("rst_eval_target", br_target, 16'h0000);
    step();
    chk("rst_eval_valid3", br_valid, 1'b0);

    // Normal operation resumes
    run_jcc("recover", 4'h5, 5'b00000, 16'h0700, 16'h0100, 1'b1, 16'h0800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the 8086 register file (16-bit IP/CX, 5-bit logic flags).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 flush  input  1  abort any in-flight branch; highest priority after rst.
REQ-005 req_valid  input  1  decoded conditional-branch/loop request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 is_cx  input  1  request is a CX-class op (jcxz/loop/loopz/loopnz).
REQ-008 cond  input  4  condition code; Jcc encoding when is_cx=0, CX-op select when is_cx=1.
REQ-009 disp  input  16  sign-extended branch displacement.
REQ-010 ip_next  input  16  IP of the instruction following the branch.
REQ-011 cx_in  input  16  current CX register value.
REQ-012 logic_flags  input  5  {OF,SF,ZF,PF,CF} from the flags register.
REQ-013 cx_we  output  1  CX write strobe, one cycle.
REQ-014 cx_out  output  16  decremented CX value, valid while cx_we=1.
REQ-015 br_valid  output  1  branch outcome available.
REQ-016 br_ready  input  1  fetch unit consumes the outcome.
REQ-017 br_taken  output  1  branch resolved taken.
REQ-018 br_target  output  16  next IP: ip_next+disp if taken, else ip_next.

Function
REQ-019 FSM states SHALL be IDLE, DEC, EVAL, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE with req_valid=1, the block SHALL capture is_cx, cond, disp, ip_next, cx_in and logic_flags; flags are not re-sampled afterwards.
REQ-021 From IDLE, an accepted request SHALL go to DEC if is_cx=1 and cond!=0 (loop family), otherwise to EVAL.
REQ-022 DEC SHALL assert cx_we for exactly one cycle with cx_out=captured CX-1 modulo 2^16 (0x0000 -> 0xFFFF), update the captured CX to that value, then go to EVAL.
REQ-023 EVAL SHALL evaluate on captured flags and captured (possibly decremented) CX. CX ops: 0 jcxz CX==0; 1 loop CX!=0; 2 loopz ZF&CX!=0; 3..15 loopnz ~ZF&CX!=0. Jcc ops: 0 O,1 NO,2 C,3 NC,4 Z,5 NZ,6 CF|ZF,7 ~CF&~ZF,8 S,9 NS,A P,B NP,C SF^OF,D ~(SF^OF),E ZF|(SF^OF),F ~ZF&~(SF^OF).
REQ-024 EVAL SHALL register br_taken and br_target (16-bit add, carry discarded), then go to RESP.
REQ-025 RESP SHALL hold br_valid=1 with stable br_taken/br_target until the cycle br_ready=1, then return to IDLE; br_valid SHALL be 0 in all other states.
REQ-026 Latency from acceptance SHALL be: br_valid in cycle 2 for Jcc/jcxz and cycle 3 for loop family.
REQ-027 A new request SHALL NOT be accepted in the cycle RESP completes; the earliest acceptance is the following cycle, in IDLE.
REQ-028 flush=1 in any state SHALL force IDLE next cycle, suppress cx_we and br_valid in that cycle, and discard the captured request.
REQ-029 flush=1 in IDLE with req_valid=1 SHALL NOT accept the request.

Reset
REQ-030 On rst=1 the FSM SHALL enter IDLE, and cx_we, br_valid, br_taken SHALL be 0, cx_out=0x0000 and br_target=0x0000.
REQ-031 rst asserted mid-operation, including DEC, SHALL abort without a CX write and without any br_valid pulse.

Structure
REQ-032 Condition-code constants (Jcc 0-15, CX-op 0-3) and the FSM state encoding SHALL reside in the shared CPU package.
REQ-033 Condition evaluation SHALL be performed by one instance of the existing combinational evaluator jmp_cond; the FSM, capture registers, decrementer and target adder reside in branch_seq.

Verification
REQ-034 is_cx=0, cond=4, flags ZF=1, ip_next=0x0100, disp=0xFFF0 -> br_valid cycle 2, br_taken=1, br_target=0x00F0, cx_we never asserted.
REQ-035 is_cx=1, cond=1, cx_in=0x0001, ip_next=0x0200, disp=0x0010 -> cx_we once with cx_out=0x0000; br_taken=0, br_target=0x0200, br_valid cycle 3.
REQ-036 is_cx=1, cond=1, cx_in=0x0000 -> cx_out=0xFFFF, br_taken=1.
REQ-037 is_cx=1, cond=0, cx_in=0x0000 -> no cx_we, br_taken=1; with ip_next=0xFFF0 and disp=0x0020 -> br_target=0x0010.
REQ-038 br_ready held 0 for 5 cycles in RESP -> br_valid and outputs stable for 5 cycles; req_ready=0 throughout; acceptance resumes the cycle after the br_ready=1 handshake.
REQ-039 flush during DEC, and rst during EVAL -> no cx_we, no br_valid, IDLE with req_ready=1 next cycle.
